// File: rtl/image_feeder.sv
// -----------------------------------------------------------------------------
// image_feeder
//
// Collects one image of IM_WID x IM_HEI 8-bit pixels from a host stream,
// packs four pixels per 32-bit word (first pixel in the LSB byte) into an
// internal word buffer, then streams the words to a classifier with a
// valid/ready handshake.  After the stream it waits for the classifier's
// result, reports it, and keeps running image / correct-answer counters.
//
// Ports
//   clk, rst             single clock, asynchronous active-high reset
//   pix_in/valid/sof     host pixel stream; pix_sof marks pixel 0 of an image
//   pix_ready            high while the block can take pixels (IDLE, FILL)
//   mode_in, label_in    per-image mode (00 train, 01 test, 10 classify,
//                        11 reserved) and true label, latched with pix_sof
//   start_main           one-cycle pulse announcing a new image
//   train_test_classify  mode of the image being processed
//   test_label           label of the image being processed
//   image_in/valid_image packed pixel words towards the classifier
//   ready                classifier accepts the current word
//   image_label          classifier result, captured when valid_all is high
//   valid_all            result valid (only observed while waiting for it)
//   result_label/valid   captured result and its one-cycle strobe
//   img_count            images completed (16-bit, wraps)
//   correct_count        test-mode images whose result matched the label
//   clear_stats          synchronous clear of both counters (beats increment)
// -----------------------------------------------------------------------------
module image_feeder #(
    parameter int IM_WID = 28,
    parameter int IM_HEI = 28
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic [1:0]  mode_in,
    input  logic [7:0]  label_in,

    output logic        start_main,
    output logic [1:0]  train_test_classify,
    output logic [7:0]  test_label,
    output logic [31:0] image_in,
    output logic        valid_image,
    input  logic        ready,
    input  logic [7:0]  image_label,
    input  logic        valid_all,

    output logic [7:0]  result_label,
    output logic        result_valid,
    output logic [15:0] img_count,
    output logic [15:0] correct_count,
    input  logic        clear_stats
);

    // -------------------------------------------------------------------------
    // State table
    //   state   | meaning
    //   IDLE    | waiting for a pixel with pix_sof; other pixels are dropped
    //   FILL    | receiving pixels 1..NPIX-1 into the word buffer
    //   START   | one cycle: pulse start_main, publish mode/label, prefetch word 0
    //   STREAM  | presenting words 0..NWORDS-1 to the classifier
    //   WAIT    | waiting for valid_all from the classifier
    //   DONE    | one cycle: result_valid high, counters update
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int NPIX   = IM_WID * IM_HEI;
    localparam int NWORDS = NPIX / 4;
    localparam int PW     = $clog2(NPIX);
    localparam int AW     = $clog2(NWORDS);
    localparam int CW     = $clog2(NWORDS + 1);

    localparam logic [1:0] MODE_TEST     = 2'b01;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    logic [2:0]    state;
    logic [PW-1:0] pix_idx;
    logic [CW-1:0] word_idx;
    logic [23:0]   pack_acc;
    logic [1:0]    mode_lat;
    logic [7:0]    label_lat;

    logic [15:0]   img_cnt_q;
    logic [15:0]   corr_cnt_q;

    logic [31:0]   img_buf [NWORDS];

    logic          pix_acc;
    logic          first_pix;
    logic          fill_pix;
    logic          last_pix;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [31:0]   buf_wdata;
    logic          word_xfer;
    logic          last_word;

    assign pix_ready = (state == ST_IDLE) || (state == ST_FILL);
    assign pix_acc   = pix_valid && pix_ready;

    // A pix_sof pixel restarts the image from either IDLE or FILL.
    assign first_pix = pix_acc && pix_sof;
    assign fill_pix  = pix_acc && !pix_sof && (state == ST_FILL);
    assign last_pix  = fill_pix && (pix_idx == PW'(NPIX - 1));

    // Lanes 0..2 wait in pack_acc; the word is written when lane 3 arrives.
    // Pixel 0 always comes through first_pix, so lane 3 is only ever in FILL.
    assign buf_we    = fill_pix && (pix_idx[1:0] == 2'b11);
    assign buf_waddr = AW'(pix_idx >> 2);
    assign buf_wdata = {pix_in, pack_acc};

    // word_idx points at the next word to load; once it reaches NWORDS the
    // word on image_in is the last one.
    assign word_xfer = valid_image && ready;
    assign last_word = (word_idx == CW'(NWORDS));

    assign img_count     = img_cnt_q;
    assign correct_count = corr_cnt_q;

    // Word buffer: no reset, contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            img_buf[buf_waddr] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            pix_idx             <= '0;
            word_idx            <= '0;
            pack_acc            <= '0;
            mode_lat            <= '0;
            label_lat           <= '0;
            start_main          <= 1'b0;
            train_test_classify <= '0;
            test_label          <= '0;
            image_in            <= '0;
            valid_image         <= 1'b0;
            result_label        <= '0;
            result_valid        <= 1'b0;
        end else begin
            start_main   <= 1'b0;
            result_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (first_pix) begin
                        mode_lat      <= mode_in;
                        label_lat     <= label_in;
                        pack_acc[7:0] <= pix_in;
                        pix_idx       <= PW'(1);
                        state         <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (first_pix) begin
                        // Partial image is abandoned; buffer words get overwritten.
                        mode_lat      <= mode_in;
                        label_lat     <= label_in;
                        pack_acc[7:0] <= pix_in;
                        pix_idx       <= PW'(1);
                    end else if (fill_pix) begin
                        case (pix_idx[1:0])
                            2'b00:   pack_acc[7:0]   <= pix_in;
                            2'b01:   pack_acc[15:8]  <= pix_in;
                            2'b10:   pack_acc[23:16] <= pix_in;
                            default: ;
                        endcase
                        if (last_pix) begin
                            pix_idx <= '0;
                            if (mode_lat == MODE_RESERVED) begin
                                state <= ST_IDLE;
                            end else begin
                                state      <= ST_START;
                                start_main <= 1'b1;
                            end
                        end else begin
                            pix_idx <= pix_idx + PW'(1);
                        end
                    end
                end

                ST_START: begin
                    train_test_classify <= mode_lat;
                    test_label          <= label_lat;
                    image_in            <= img_buf[0];
                    valid_image         <= 1'b1;
                    word_idx            <= CW'(1);
                    state               <= ST_STREAM;
                end

                ST_STREAM: begin
                    if (word_xfer) begin
                        if (last_word) begin
                            valid_image <= 1'b0;
                            word_idx    <= '0;
                            state       <= ST_WAIT;
                        end else begin
                            image_in <= img_buf[word_idx[AW-1:0]];
                            word_idx <= word_idx + CW'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    if (valid_all) begin
                        result_label <= image_label;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Statistics.  The update happens on the edge that leaves DONE, when
    // result_label and test_label are both settled for this image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_cnt_q  <= '0;
            corr_cnt_q <= '0;
        end else if (clear_stats) begin
            img_cnt_q  <= '0;
            corr_cnt_q <= '0;
        end else if (state == ST_DONE) begin
            img_cnt_q <= img_cnt_q + 16'd1;
            if ((train_test_classify == MODE_TEST) && (result_label == test_label)) begin
                corr_cnt_q <= corr_cnt_q + 16'd1;
            end
        end
    end

endmodule
